// File: rtl/traffic_phase_timer.sv
// traffic_phase_timer: round-robin GREEN/YELLOW/ALL_RED sequencer with a
// tick-driven phase counter, shadowed durations and an emergency hold.
module traffic_phase_timer #(
  parameter int WIDTH      = 8,
  parameter int NUM_DIR    = 2,
  parameter int DIR_W      = $clog2(NUM_DIR),
  parameter int GREEN_DEF  = 30,
  parameter int YELLOW_DEF = 3,
  parameter int ALLRED_DEF = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               cfg_load,
  input  logic [WIDTH-1:0]   green_time,
  input  logic [WIDTH-1:0]   yellow_time,
  input  logic [WIDTH-1:0]   allred_time,
  input  logic               preempt,
  output logic [NUM_DIR-1:0] green,
  output logic [NUM_DIR-1:0] yellow,
  output logic [NUM_DIR-1:0] red,
  output logic [DIR_W-1:0]   dir_idx,
  output logic [WIDTH-1:0]   count,
  output logic               phase_done
);

  localparam logic [1:0] S_GREEN  = 2'd0;
  localparam logic [1:0] S_YELLOW = 2'd1;
  localparam logic [1:0] S_ALLRED = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  localparam logic [WIDTH-1:0] G_RST = WIDTH'(GREEN_DEF);
  localparam logic [WIDTH-1:0] Y_RST = WIDTH'(YELLOW_DEF);
  localparam logic [WIDTH-1:0] A_RST = WIDTH'(ALLRED_DEF);
  localparam logic [DIR_W-1:0] DIR_LAST = DIR_W'(NUM_DIR - 1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic [DIR_W-1:0] dir_nxt;

  logic [WIDTH-1:0] g_act;
  logic [WIDTH-1:0] y_act;
  logic [WIDTH-1:0] a_act;
  logic [WIDTH-1:0] g_sh;
  logic [WIDTH-1:0] y_sh;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] g_new;
  logic [WIDTH-1:0] y_new;
  logic [WIDTH-1:0] a_new;

  logic [WIDTH-1:0] lim;
  logic [WIDTH-1:0] last;
  logic             terminal;
  logic             adv;
  logic             enter_green;

  always_comb begin
    unique case (state)
      S_GREEN:  lim = g_act;
      S_YELLOW: lim = y_act;
      default:  lim = a_act;
    endcase
  end

  // a zero duration behaves as a one-tick phase
  assign last     = (lim == '0) ? '0 : lim - WIDTH'(1);
  assign terminal = (count == last);
  assign adv      = tick & terminal;

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    dir_nxt   = dir_idx;
    unique case (state)
      S_GREEN: begin
        if (preempt || adv) begin
          state_nxt = S_YELLOW;
          count_nxt = '0;
        end else if (tick) begin
          count_nxt = count + WIDTH'(1);
        end
      end
      S_YELLOW: begin
        if (adv) begin
          state_nxt = S_ALLRED;
          count_nxt = '0;
        end else if (tick) begin
          count_nxt = count + WIDTH'(1);
        end
      end
      S_ALLRED: begin
        if (adv) begin
          state_nxt = preempt ? S_HOLD : S_GREEN;
          count_nxt = '0;
          dir_nxt   = (dir_idx == DIR_LAST) ? '0
                    : dir_idx + DIR_W'(1);
        end else if (tick) begin
          count_nxt = count + WIDTH'(1);
        end
      end
      default: begin
        count_nxt = '0;
        if (!preempt) state_nxt = S_GREEN;
      end
    endcase
  end

  // a load coincident with green entry must take effect at once
  assign g_new = cfg_load ? green_time  : g_sh;
  assign y_new = cfg_load ? yellow_time : y_sh;
  assign a_new = cfg_load ? allred_time : a_sh;

  assign enter_green = (state_nxt == S_GREEN)
                     && (state != S_GREEN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_GREEN;
      count      <= '0;
      dir_idx    <= '0;
      phase_done <= 1'b0;
      g_sh       <= G_RST;
      y_sh       <= Y_RST;
      a_sh       <= A_RST;
      g_act      <= G_RST;
      y_act      <= Y_RST;
      a_act      <= A_RST;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      dir_idx    <= dir_nxt;
      phase_done <= (state_nxt != state);
      g_sh       <= g_new;
      y_sh       <= y_new;
      a_sh       <= a_new;
      if (enter_green) begin
        g_act <= g_new;
        y_act <= y_new;
        a_act <= a_new;
      end
    end
  end

  always_comb begin
    green  = '0;
    yellow = '0;
    unique case (1'b1)
      state == S_GREEN:  green[dir_idx]  = 1'b1;
      state == S_YELLOW: yellow[dir_idx] = 1'b1;
      default: ;
    endcase
    red = ~(green | yellow);
  end

endmodule

// File: tb/tb_traffic_phase_timer.sv
// tb_traffic_phase_timer: directed scenarios plus randomized traffic,
// checked against a phase-level behavioural model.
module tb_traffic_phase_timer;

  localparam int W  = 8;
  localparam int N  = 2;
  localparam int DW = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          tick;
  logic          cfg_load;
  logic [W-1:0]  green_time;
  logic [W-1:0]  yellow_time;
  logic [W-1:0]  allred_time;
  logic          preempt;
  logic [N-1:0]  green;
  logic [N-1:0]  yellow;
  logic [N-1:0]  red;
  logic [DW-1:0] dir_idx;
  logic [W-1:0]  count;
  logic          phase_done;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  traffic_phase_timer #(
    .WIDTH(W), .NUM_DIR(N), .DIR_W(DW),
    .GREEN_DEF(30), .YELLOW_DEF(3), .ALLRED_DEF(2)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick),
    .cfg_load(cfg_load),
    .green_time(green_time),
    .yellow_time(yellow_time),
    .allred_time(allred_time),
    .preempt(preempt),
    .green(green), .yellow(yellow), .red(red),
    .dir_idx(dir_idx), .count(count),
    .phase_done(phase_done)
  );

  // model: phase 0=green 1=yellow 2=all-red 3=hold
  int m_ph, m_dir, m_cnt;
  int m_act[3];
  int m_sh[3];
  bit m_pd;

  task automatic model_step(input bit r, input bit t,
                            input bit c, input bit p,
                            input int gt, input int yt,
                            input int at);
    int old, lim;
    int nsh[3];
    if (r) begin
      m_ph = 0; m_dir = 0; m_cnt = 0; m_pd = 0;
      m_act = '{30, 3, 2};
      m_sh  = '{30, 3, 2};
      return;
    end
    old = m_ph;
    if (c) nsh = '{gt, yt, at};
    else   nsh = m_sh;
    lim = 1;
    if (m_ph < 3) lim = (m_act[m_ph] == 0) ? 1 : m_act[m_ph];
    if (m_ph == 0 && p) begin
      m_ph = 1; m_cnt = 0;
    end else if (m_ph == 3) begin
      m_cnt = 0;
      if (!p) m_ph = 0;
    end else if (t) begin
      if (m_cnt + 1 == lim) begin
        m_cnt = 0;
        if (m_ph == 2) begin
          m_dir = (m_dir + 1) % N;
          m_ph = p ? 3 : 0;
        end else begin
          m_ph = m_ph + 1;
        end
      end else begin
        m_cnt++;
      end
    end
    m_sh = nsh;
    if (m_ph == 0 && old != 0) m_act = nsh;
    m_pd = (old != m_ph);
  endtask

  function automatic logic [31:0] model_out();
    logic [N-1:0] g, y, r;
    g = '0;
    y = '0;
    if (m_ph == 0) g[m_dir] = 1'b1;
    if (m_ph == 1) y[m_dir] = 1'b1;
    r = ~(g | y);
    return 32'({g, y, r, DW'(m_dir), W'(m_cnt), m_pd});
  endfunction

  function automatic logic [31:0] dut_out();
    return 32'({green, yellow, red, dir_idx, count, phase_done});
  endfunction

  task automatic cyc(input bit t);
    tick = t;
    @(posedge clk);
    model_step(rst, tick, cfg_load, preempt,
               int'(green_time), int'(yellow_time),
               int'(allred_time));
    #1;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      cyc(0); cyc(0); cyc(0); cyc(1);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(0);
    rst = 1'b0;
  endtask

  task automatic load_cfg(input int g, input int y, input int a);
    cfg_load = 1'b1;
    green_time = W'(g);
    yellow_time = W'(y);
    allred_time = W'(a);
    cyc(0);
    cfg_load = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    cyc(0);
    nvec++;
    if ({green, yellow, red} !== 6'b01_00_10) begin
      nerr++;
      $display("FAIL rst_lamps got %b exp %b",
               {green, yellow, red}, 6'b01_00_10);
    end
    nvec++;
    if ({dir_idx, count, phase_done} !== 10'd0) begin
      nerr++;
      $display("FAIL rst_regs got %h exp 0",
               {dir_idx, count, phase_done});
    end
  endtask

  task automatic test_defaults();
    do_reset();
    wait_ticks(29);
    nvec++;
    if (green !== 2'b01 || count !== 8'd29) begin
      nerr++;
      $display("FAIL def_g29 got g=%b c=%0d exp g=01 c=29",
               green, count);
    end
    wait_ticks(1);
    nvec++;
    if (yellow !== 2'b01 || phase_done !== 1'b1) begin
      nerr++;
      $display("FAIL def_yel got y=%b pd=%b exp y=01 pd=1",
               yellow, phase_done);
    end
    cyc(0);
    nvec++;
    if (phase_done !== 1'b0) begin
      nerr++;
      $display("FAIL def_pd1 got %b exp 0", phase_done);
    end
    wait_ticks(3);
    nvec++;
    if (red !== 2'b11) begin
      nerr++;
      $display("FAIL def_allred got %b exp 11", red);
    end
    wait_ticks(2);
    nvec++;
    if (green !== 2'b10 || dir_idx !== 1'b1) begin
      nerr++;
      $display("FAIL def_dir1 got g=%b d=%0d exp g=10 d=1",
               green, dir_idx);
    end
    wait_ticks(35);
    nvec++;
    if (green !== 2'b01 || dir_idx !== 1'b0) begin
      nerr++;
      $display("FAIL def_wrap got g=%b d=%0d exp g=01 d=0",
               green, dir_idx);
    end
  endtask

  task automatic test_reconfig();
    do_reset();
    wait_ticks(10);
    load_cfg(5, 1, 1);
    wait_ticks(19);
    nvec++;
    if (green !== 2'b01 || count !== 8'd29) begin
      nerr++;
      $display("FAIL cfg_g0 got g=%b c=%0d exp g=01 c=29",
               green, count);
    end
    wait_ticks(1);
    nvec++;
    if (yellow !== 2'b01) begin
      nerr++;
      $display("FAIL cfg_y0 got %b exp 01", yellow);
    end
    wait_ticks(5);
    nvec++;
    if (green !== 2'b10) begin
      nerr++;
      $display("FAIL cfg_g1 got %b exp 10", green);
    end
    wait_ticks(4);
    nvec++;
    if (green !== 2'b10 || count !== 8'd4) begin
      nerr++;
      $display("FAIL cfg_g1_4 got g=%b c=%0d exp g=10 c=4",
               green, count);
    end
    wait_ticks(1);
    nvec++;
    if (yellow !== 2'b10) begin
      nerr++;
      $display("FAIL cfg_y1 got %b exp 10", yellow);
    end
    wait_ticks(1);
    nvec++;
    if (red !== 2'b11) begin
      nerr++;
      $display("FAIL cfg_r1 got %b exp 11", red);
    end
    wait_ticks(1);
    nvec++;
    if (green !== 2'b01 || dir_idx !== 1'b0) begin
      nerr++;
      $display("FAIL cfg_back got g=%b d=%0d exp g=01 d=0",
               green, dir_idx);
    end
  endtask

  task automatic test_preempt();
    do_reset();
    wait_ticks(12);
    cyc(0);
    preempt = 1'b1;
    cyc(0);
    nvec++;
    if (yellow !== 2'b01 || count !== 8'd0) begin
      nerr++;
      $display("FAIL pre_yel got y=%b c=%0d exp y=01 c=0",
               yellow, count);
    end
    wait_ticks(2);
    nvec++;
    if (yellow !== 2'b01 || count !== 8'd2) begin
      nerr++;
      $display("FAIL pre_yfull got y=%b c=%0d exp y=01 c=2",
               yellow, count);
    end
    wait_ticks(3);
    wait_ticks(2);
    nvec++;
    if (red !== 2'b11 || dir_idx !== 1'b1) begin
      nerr++;
      $display("FAIL pre_hold got r=%b d=%0d exp r=11 d=1",
               red, dir_idx);
    end
    for (int i = 0; i < 20; i++) begin
      wait_ticks(1);
      nvec++;
      if (red !== 2'b11 || count !== 8'd0) begin
        nerr++;
        $display("FAIL pre_held%0d got r=%b c=%0d exp r=11 c=0",
                 i, red, count);
      end
    end
    preempt = 1'b0;
    cyc(0);
    nvec++;
    if (green !== 2'b10 || dir_idx !== 1'b1
        || phase_done !== 1'b1) begin
      nerr++;
      $display("FAIL pre_rel got g=%b d=%0d pd=%b exp 10/1/1",
               green, dir_idx, phase_done);
    end
  endtask

  task automatic test_zero();
    do_reset();
    load_cfg(2, 0, 1);
    wait_ticks(35);
    nvec++;
    if (green !== 2'b10) begin
      nerr++;
      $display("FAIL zero_g1 got %b exp 10", green);
    end
    wait_ticks(2);
    nvec++;
    if (yellow !== 2'b10) begin
      nerr++;
      $display("FAIL zero_y1 got %b exp 10", yellow);
    end
    wait_ticks(1);
    nvec++;
    if (red !== 2'b11 || count !== 8'd0) begin
      nerr++;
      $display("FAIL zero_ylen got r=%b c=%0d exp r=11 c=0",
               red, count);
    end
    wait_ticks(1);
    nvec++;
    if (green !== 2'b01) begin
      nerr++;
      $display("FAIL zero_g0 got %b exp 01", green);
    end
  endtask

  task automatic test_midreset();
    do_reset();
    load_cfg(7, 5, 2);
    wait_ticks(35);
    wait_ticks(7);
    wait_ticks(2);
    nvec++;
    if (yellow !== 2'b10 || count !== 8'd2) begin
      nerr++;
      $display("FAIL mid_pre got y=%b c=%0d exp y=10 c=2",
               yellow, count);
    end
    rst = 1'b1;
    cyc(0);
    rst = 1'b0;
    nvec++;
    if ({green, dir_idx, count, phase_done} !== 12'h400) begin
      nerr++;
      $display("FAIL mid_rst got %h exp 400",
               {green, dir_idx, count, phase_done});
    end
    wait_ticks(29);
    nvec++;
    if (green !== 2'b01) begin
      nerr++;
      $display("FAIL mid_gdef got %b exp 01", green);
    end
    wait_ticks(1);
    wait_ticks(2);
    nvec++;
    if (yellow !== 2'b01) begin
      nerr++;
      $display("FAIL mid_ydef got %b exp 01", yellow);
    end
    wait_ticks(1);
    nvec++;
    if (red !== 2'b11) begin
      nerr++;
      $display("FAIL mid_rdef got %b exp 11", red);
    end
  endtask

  task automatic test_coincident();
    do_reset();
    wait_ticks(29);
    cyc(0);
    cyc(0);
    preempt = 1'b1;
    cyc(1);
    nvec++;
    if (yellow !== 2'b01 || count !== 8'd0
        || phase_done !== 1'b1) begin
      nerr++;
      $display("FAIL coin_yel got y=%b c=%0d pd=%b exp 01/0/1",
               yellow, count, phase_done);
    end
    cyc(0);
    nvec++;
    if (phase_done !== 1'b0 || yellow !== 2'b01) begin
      nerr++;
      $display("FAIL coin_pd got pd=%b y=%b exp pd=0 y=01",
               phase_done, yellow);
    end
    preempt = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      cfg_load = ($urandom_range(0, 24) == 0);
      green_time = W'($urandom_range(0, 5));
      yellow_time = W'($urandom_range(0, 3));
      allred_time = W'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) preempt = ~preempt;
      cyc(1'($urandom_range(0, 1)));
      nvec++;
      if (dut_out() !== model_out()) begin
        nerr++;
        $display("FAIL rand%0d got %h exp %h",
                 i, dut_out(), model_out());
      end
    end
    rst = 1'b0;
    cfg_load = 1'b0;
    preempt = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tick = 1'b0;
    cfg_load = 1'b0;
    preempt = 1'b0;
    green_time = '0;
    yellow_time = '0;
    allred_time = '0;
    m_ph = 0; m_dir = 0; m_cnt = 0; m_pd = 0;
    m_act = '{30, 3, 2};
    m_sh = '{30, 3, 2};
    test_reset();
    test_defaults();
    test_reconfig();
    test_preempt();
    test_zero();
    test_midreset();
    test_coincident();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule

// File: doc/traffic_phase_timer.md
Name: traffic_phase_timer

Overview:
- Parametrised phase sequencer for an N-approach intersection; successor to the fixed green/yellow threshold comparator.
- Owns its own tick-driven counter and runs a GREEN -> YELLOW -> ALL_RED cycle per approach, rotating round-robin across NUM_DIR approaches.
- Phase durations are runtime-programmable through a shadow register with boundary-safe update.
- An emergency preempt input forces all approaches to red.
- Sits between the 1 Hz tick generator and the lamp drivers.

Parameters:
- WIDTH, 8, width of duration inputs and phase counter
- NUM_DIR, 2, number of approaches (>=2)
- DIR_W, $clog2(NUM_DIR), width of dir_idx
- GREEN_DEF, 30, green duration in ticks loaded at reset
- YELLOW_DEF, 3, yellow duration in ticks loaded at reset
- ALLRED_DEF, 2, all-red clearance duration in ticks loaded at reset

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- tick  in  1  one-clk-wide timing pulse; counter advances only on tick
- cfg_load  in  1  capture green_time/yellow_time/allred_time into shadow registers
- green_time  in  WIDTH  new green duration in ticks
- yellow_time  in  WIDTH  new yellow duration in ticks
- allred_time  in  WIDTH  new all-red duration in ticks
- preempt  in  1  emergency request; level-sensitive
- green  out  NUM_DIR  per-approach green lamp
- yellow  out  NUM_DIR  per-approach yellow lamp
- red  out  NUM_DIR  per-approach red lamp
- dir_idx  out  DIR_W  approach currently served
- count  out  WIDTH  ticks elapsed in current phase
- phase_done  out  1  one-cycle pulse after every state change

Behaviour:
- States: GREEN, YELLOW, ALL_RED, HOLD.
- Reset, on any clk edge with rst=1 (including mid-phase):
  - state=GREEN, dir_idx=0, count=0, phase_done=0.
  - Active and shadow durations = GREEN_DEF/YELLOW_DEF/ALLRED_DEF.
  - Outputs: green=one-hot bit0, yellow=0, red=all ones except bit0.
- Lamp decode, from registered state and dir_idx only; no combinational input-to-output path:
  - GREEN: green[dir_idx]=1.
  - YELLOW: yellow[dir_idx]=1.
  - ALL_RED/HOLD: all red.
  - Every approach not lit green/yellow shows red. Exactly one lamp per approach is set at all times.
- Timing:
  - A zero duration is treated as 1.
  - On a clk edge with tick=1, if count == limit-1 the state advances and count<=0; otherwise count<=count+1.
  - A phase therefore lasts exactly limit ticks.
  - tick=0: count holds.
- Transitions:
  - GREEN -> YELLOW.
  - YELLOW -> ALL_RED.
  - ALL_RED -> GREEN (preempt=0) or HOLD (preempt=1).
  - dir_idx advances on every ALL_RED exit; NUM_DIR-1 wraps to 0.
- Preempt:
  - preempt=1 in GREEN: next clk edge goes to YELLOW with count=0, regardless of tick.
  - YELLOW/ALL_RED complete their full durations.
  - HOLD: count held at 0, ticks ignored.
  - preempt=0 in HOLD: next clk edge goes to GREEN of the current dir_idx; no further dir advance.
- Config:
  - cfg_load=1 writes the three shadow registers on that edge.
  - Active registers copy the shadow only on the edge that enters GREEN, so a running phase never changes length.
  - cfg_load coincident with GREEN entry: the newly loaded values take effect immediately.
- phase_done: registered; high for exactly one clk in the cycle after any state-register change; 0 otherwise and during/after reset.
- Simultaneous events: rst has priority over everything. preempt in GREEN has priority over a coincident terminal tick; the result is still YELLOW with count=0.
- Width: count never exceeds limit-1, so no overflow. Max phase = 2^WIDTH-1 ticks.

Test Plan:
- Defaults, NUM_DIR=2, tick every 4 clk:
  - Release rst -> green=01, red=10.
  - After 30 ticks -> yellow=01, phase_done pulse.
  - After 3 more -> red=11.
  - After 2 more -> green=10, dir_idx=1.
  - After 70 ticks total -> green=01, dir_idx=0.
- Reconfig: cfg_load with 5/1/1 at tick 10 of dir-0 green.
  - dir-0 green still lasts 30 ticks.
  - dir-1 green lasts 5, yellow 1, all-red 1.
- Preempt: assert preempt at tick 12 of green, between ticks.
  - Next clk -> yellow, count=0.
  - 3 ticks -> ALL_RED; 2 ticks -> HOLD, red=11 held across 20 ticks.
  - Drop preempt -> next clk green on dir_idx=1.
- Zero duration: yellow_time=0 loaded -> yellow lasts exactly 1 tick.
- Mid-phase reset: rst=1 at yellow tick 2 of dir 1 -> next edge green=01, count=0, dir_idx=0, durations back to defaults.
- Coincident events: preempt rises on the same edge as the green terminal tick -> YELLOW, count=0, single phase_done pulse.
